decode_stage: RTL and testbench

//  ID stage of the 5-stage MIPS R2000 pipeline, directly downstream of IF. Consumes IF's pc/inst,

---
 rtl/mips_pkg.sv | 56 +++++
 rtl/decode_regfile.sv | 38 +++
 rtl/decode_stage.sv | 163 ++++++++++++++++
 tb/tb_decode_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS R2000 decode stage.
// The opcode, funct and ALU encodings, the control bundle, and the fixed vectors all live here.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;

  localparam logic [DATA_W-1:0] EXC_VECTOR = 32'h8000_0180;
  localparam logic [DATA_W-1:0] NOP        = 32'h0000_0000;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    F_SLL = 6'h00,
    F_ADD = 6'h20,
    F_SUB = 6'h22,
    F_AND = 6'h24,
    F_OR  = 6'h25,
    F_SLT = 6'h2A
  } funct_e;

  // ALU_LUI passes the pre-shifted immediate straight through.
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5,
    ALU_LUI = 4'd6
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
  } ctrl_t;

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x32 register file: two read ports, one write port, write-through bypass, r0 reads zero.
// Synchronous active-high reset clears every register.
module decode_regfile
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs_addr_i,
  input  logic [4:0]        rt_addr_i,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  // NOTE: the array is reset because a post-reset read must return 0; this keeps it in flops, not SRAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != 5'd0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Same-cycle writeback is forwarded so ID never sees a stale value.
  always_comb begin
    rs_data_o = regs_q[rs_addr_i];
    rt_data_o = regs_q[rt_addr_i];
    if (we_i && waddr_i == rs_addr_i) rs_data_o = wdata_i;
    if (we_i && waddr_i == rt_addr_i) rt_data_o = wdata_i;
    if (rs_addr_i == 5'd0) rs_data_o = '0;
    if (rt_addr_i == 5'd0) rt_data_o = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// ID stage: decode, register read, hazard detection, branch/jump resolution, ID/EX latch.
// Resolves control flow in ID so IF redirects with no delay slot.
module decode_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] inst_in,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_dest,
  input  logic              mem_reg_write,
  input  logic [4:0]        mem_dest,
  output logic              hold_pc,
  output logic              hold_if,
  output logic              br,
  output logic [DATA_W-1:0] pc_branch,
  output logic              except,
  output logic [DATA_W-1:0] epc,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [DATA_W-1:0] id_rt_data,
  output logic [DATA_W-1:0] id_imm,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_dest,
  output ctrl_t             id_ctrl
);

  opcode_e           op;
  funct_e            funct;
  logic [4:0]        rs, rt, rd;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] rs_data, rt_data, pc_plus4;

  ctrl_t             ctrl_d;
  logic [DATA_W-1:0] imm_d;
  logic [4:0]        dest_d;
  logic              illegal, rt_used, is_beq, is_bne, is_j;
  logic              load_use, br_hazard, stall, taken, bubble;

  assign op    = opcode_e'(inst_in[31:26]);
  assign funct = funct_e'(inst_in[5:0]);
  assign rs    = inst_in[25:21];
  assign rt    = inst_in[20:16];
  assign rd    = inst_in[15:11];
  assign imm16 = inst_in[15:0];

  decode_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rs_addr_i (rs),
    .rt_addr_i (rt),
    .we_i      (wb_we),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .rs_data_o (rs_data),
    .rt_data_o (rt_data)
  );

  // NOTE: every output gets a default first so no path through the case leaves a latch.
  always_comb begin
    ctrl_d  = '0;
    imm_d   = sext16(imm16);
    dest_d  = 5'd0;
    illegal = 1'b0;
    rt_used = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        dest_d           = rd;
        rt_used          = 1'b1;
        ctrl_d.reg_write = 1'b1;
        imm_d            = {27'd0, inst_in[10:6]};
        unique case (funct)
          F_ADD:   ctrl_d.alu_op = ALU_ADD;
          F_SUB:   ctrl_d.alu_op = ALU_SUB;
          F_AND:   ctrl_d.alu_op = ALU_AND;
          F_OR:    ctrl_d.alu_op = ALU_OR;
          F_SLT:   ctrl_d.alu_op = ALU_SLT;
          F_SLL:   ctrl_d.alu_op = ALU_SLL;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
        dest_d           = rt;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.mem_read  = (op == OP_LW);
        unique case (op)
          OP_ANDI: begin ctrl_d.alu_op = ALU_AND; imm_d = {16'd0, imm16}; end
          OP_ORI:  begin ctrl_d.alu_op = ALU_OR;  imm_d = {16'd0, imm16}; end
          OP_LUI:  begin ctrl_d.alu_op = ALU_LUI; imm_d = {imm16, 16'd0}; end
          default: ctrl_d.alu_op = ALU_ADD;
        endcase
      end
      OP_SW: begin
        rt_used          = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        rt_used       = 1'b1;
        ctrl_d.alu_op = ALU_SUB;
        is_beq        = (op == OP_BEQ);
        is_bne        = (op == OP_BNE);
      end
      OP_J:    is_j = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  // Branches compare in ID, so any in-flight producer of rs/rt must drain first.
  assign load_use  = ex_mem_read && ex_dest != 5'd0 &&
                     (ex_dest == rs || (rt_used && ex_dest == rt));
  assign br_hazard = (is_beq || is_bne) &&
                     ((ex_reg_write && ex_dest != 5'd0 && (ex_dest == rs || ex_dest == rt)) ||
                      (mem_reg_write && mem_dest != 5'd0 && (mem_dest == rs || mem_dest == rt)));
  assign stall     = load_use || br_hazard;

  assign taken     = is_j || (is_beq && rs_data == rt_data) || (is_bne && rs_data != rt_data);
  assign pc_plus4  = pc_in + 32'd4;
  assign pc_branch = is_j ? {pc_plus4[31:28], inst_in[25:0], 2'b00}
                          : pc_plus4 + {imm_d[29:0], 2'b00};

  assign hold_pc = !rst && stall;
  assign hold_if = !rst && stall;
  assign except  = !rst && !stall && illegal;
  assign br      = !rst && !stall && !illegal && taken;
  assign bubble  = stall || illegal || taken;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      epc        <= '0;
      id_pc      <= '0;
      id_rs_data <= '0;
      id_rt_data <= '0;
      id_imm     <= '0;
      id_rs      <= '0;
      id_rt      <= '0;
      id_dest    <= '0;
      id_ctrl    <= '0;
    end else begin
      if (except) epc <= pc_in;
      id_pc      <= pc_in;
      id_rs_data <= rs_data;
      id_rt_data <= rt_data;
      id_imm     <= imm_d;
      id_rs      <= rs;
      id_rt      <= rt;
      id_dest    <= bubble ? 5'd0 : dest_d;
      id_ctrl    <= bubble ? ctrl_t'('0) : ctrl_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: register read/bypass, hazards, branches, exceptions, reset.
// Expected values are hand-computed from the instruction encodings.
module tb_decode_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, inst_in, wb_data;
  logic        wb_we, ex_reg_write, ex_mem_read, mem_reg_write;
  logic [4:0]  wb_addr, ex_dest, mem_dest;
  logic        hold_pc, hold_if, br, except;
  logic [31:0] pc_branch, epc, id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_dest;
  ctrl_t       id_ctrl;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_in         (pc_in),
    .inst_in       (inst_in),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_dest       (ex_dest),
    .mem_reg_write (mem_reg_write),
    .mem_dest      (mem_dest),
    .hold_pc       (hold_pc),
    .hold_if       (hold_if),
    .br            (br),
    .pc_branch     (pc_branch),
    .except        (except),
    .epc           (epc),
    .id_pc         (id_pc),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .id_imm        (id_imm),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_dest       (id_dest),
    .id_ctrl       (id_ctrl)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge so registered outputs are stable.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] pc, input logic [31:0] inst);
    pc_in   = pc;
    inst_in = inst;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b1;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_dest = 5'd0;
    mem_reg_write = 1'b0; mem_dest = 5'd0;
    put(32'h0, 32'hFC00_0000);
    repeat (2) tick;
    check("rst_except", {31'd0, except}, 32'd0);
    check("rst_hold_pc", {31'd0, hold_pc}, 32'd0);
    check("rst_br", {31'd0, br}, 32'd0);
    check("rst_epc", epc, 32'd0);
    check("rst_ctrl", {24'd0, id_ctrl}, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_dest", {27'd0, id_dest}, 32'd0);

    // Writeback r5 then ADDI r6,r5,-1
    rst = 1'b0;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    put(32'h0, NOP);
    tick;
    wb_we = 1'b0;
    put(32'h10, 32'h20A6_FFFF);
    check("addi_except", {31'd0, except}, 32'd0);
    check("addi_hold", {31'd0, hold_pc}, 32'd0);
    check("addi_br", {31'd0, br}, 32'd0);
    tick;
    check("addi_rs_data", id_rs_data, 32'h1234);
    check("addi_imm", id_imm, 32'hFFFF_FFFF);
    check("addi_dest", {27'd0, id_dest}, 32'd6);
    check("addi_ctrl", {24'd0, id_ctrl}, 32'h0C);
    check("addi_pc", id_pc, 32'h10);
    check("addi_rs", {27'd0, id_rs}, 32'd5);

    // Same-cycle writeback bypass, then writes to r0 are dropped
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hAA;
    put(32'h14, 32'h00A5_3820);
    tick;
    check("byp_rs_data", id_rs_data, 32'hAA);
    check("byp_rt_data", id_rt_data, 32'hAA);
    check("byp_dest", {27'd0, id_dest}, 32'd7);
    check("add_ctrl", {24'd0, id_ctrl}, 32'h04);
    wb_addr = 5'd0; wb_data = 32'hDEAD;
    put(32'h18, 32'h0000_3820);
    tick;
    check("r0_bypass", id_rs_data, 32'd0);
    wb_we = 1'b0;
    tick;
    check("r0_read", id_rt_data, 32'd0);

    // Load-use stall on rs, then release
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd5;
    put(32'h20, 32'h00A0_3820);
    check("lu_hold_pc", {31'd0, hold_pc}, 32'd1);
    check("lu_hold_if", {31'd0, hold_if}, 32'd1);
    tick;
    check("lu_bubble_ctrl", {24'd0, id_ctrl}, 32'd0);
    check("lu_bubble_dest", {27'd0, id_dest}, 32'd0);
    ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    #1;
    check("lu_release", {31'd0, hold_pc}, 32'd0);
    tick;
    check("lu_ctrl", {24'd0, id_ctrl}, 32'h04);
    check("lu_dest", {27'd0, id_dest}, 32'd7);
    check("lu_rs_data", id_rs_data, 32'hAA);
    // Load into rt of an I-type (rt not a source) and into r0 must not stall
    ex_mem_read = 1'b1; ex_dest = 5'd6;
    put(32'h24, 32'h20A6_FFFF);
    check("lu_rt_unused", {31'd0, hold_pc}, 32'd0);
    ex_dest = 5'd0;
    put(32'h24, 32'h0000_3820);
    check("lu_r0", {31'd0, hold_pc}, 32'd0);
    ex_mem_read = 1'b0;

    // r1 = r2 = 3, then branches
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd3;
    put(32'h28, NOP);
    tick;
    wb_addr = 5'd2;
    tick;
    wb_we = 1'b0;
    put(32'h40, 32'h1022_0004);
    check("beq_br", {31'd0, br}, 32'd1);
    check("beq_target", pc_branch, 32'h54);
    check("beq_hold", {31'd0, hold_pc}, 32'd0);
    tick;
    check("beq_bubble", {24'd0, id_ctrl}, 32'd0);
    put(32'h40, 32'h1422_0004);
    check("bne_br", {31'd0, br}, 32'd0);
    tick;
    check("bne_ctrl", {24'd0, id_ctrl}, 32'h10);
    check("bne_rs_data", id_rs_data, 32'd3);
    put(32'h40, 32'h1022_FFFF);
    check("beq_back_target", pc_branch, 32'h40);
    check("beq_back_br", {31'd0, br}, 32'd1);
    put(32'hFFFF_FFFC, 32'h1022_0000);
    check("beq_wrap_target", pc_branch, 32'h0);
    mem_reg_write = 1'b1; mem_dest = 5'd2;
    put(32'h40, 32'h1022_0004);
    check("br_mem_hold", {31'd0, hold_pc}, 32'd1);
    check("br_mem_br", {31'd0, br}, 32'd0);
    tick;
    check("br_mem_bubble", {24'd0, id_ctrl}, 32'd0);
    mem_reg_write = 1'b0; mem_dest = 5'd0;
    ex_reg_write = 1'b1; ex_dest = 5'd1;
    #1;
    check("br_ex_hold", {31'd0, hold_if}, 32'd1);
    ex_reg_write = 1'b0; ex_dest = 5'd0;
    put(32'h40, 32'h0800_0100);
    check("j_br", {31'd0, br}, 32'd1);
    check("j_target", pc_branch, 32'h400);
    tick;
    check("j_bubble", {24'd0, id_ctrl}, 32'd0);
    put(32'hF000_0040, 32'h0800_0100);
    check("j_region", pc_branch, 32'hF000_0400);

    // Reserved instructions
    put(32'h88, 32'hFC00_0000);
    check("ill_except", {31'd0, except}, 32'd1);
    check("ill_br", {31'd0, br}, 32'd0);
    check("ill_hold", {31'd0, hold_pc}, 32'd0);
    tick;
    check("ill_epc", epc, 32'h88);
    check("ill_bubble", {24'd0, id_ctrl}, 32'd0);
    put(32'h90, 32'h00A5_3821);
    check("ill_funct", {31'd0, except}, 32'd1);
    tick;
    check("ill_funct_epc", epc, 32'h90);
    ex_mem_read = 1'b1; ex_dest = 5'd5;
    put(32'h98, 32'hFCA0_0000);
    check("ill_stalled_except", {31'd0, except}, 32'd0);
    check("ill_stalled_hold", {31'd0, hold_pc}, 32'd1);
    tick;
    check("ill_stalled_epc", epc, 32'h90);
    ex_mem_read = 1'b0; ex_dest = 5'd0;
    #1;
    check("ill_deferred", {31'd0, except}, 32'd1);
    tick;
    check("ill_deferred_epc", epc, 32'h98);

    // Reset while stalled
    ex_mem_read = 1'b1; ex_dest = 5'd5;
    put(32'hA0, 32'h00A0_3820);
    check("pre_rst_hold", {31'd0, hold_pc}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_hold_pc", {31'd0, hold_pc}, 32'd0);
    check("rst_mid_hold_if", {31'd0, hold_if}, 32'd0);
    tick;
    check("rst2_epc", epc, 32'd0);
    check("rst2_ctrl", {24'd0, id_ctrl}, 32'd0);
    check("rst2_id_pc", id_pc, 32'd0);
    check("rst2_rs_data", id_rs_data, 32'd0);
    check("rst2_dest", {27'd0, id_dest}, 32'd0);
    rst = 1'b0;
    ex_mem_read = 1'b0; ex_dest = 5'd0;
    put(32'h100, 32'h00A5_3820);
    tick;
    check("rf_cleared", id_rs_data, 32'd0);
    check("post_rst_ctrl", {24'd0, id_ctrl}, 32'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
